// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential I-cache reads against a credit limit and buffers
// {pc+4, instruction} pairs in a first-word-fall-through circular queue with redirect flush.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_icache_addr,
    output logic        o_icache_rd_en,
    input  logic [31:0] i_icache_data,
    output logic [31:0] o_fetch_pc_plus_4,
    output logic [31:0] o_fetch_instruction,
    output logic        o_fetch_empty_flag,
    input  logic        i_rd_en,
    input  logic        i_jmp_valid,
    input  logic [31:0] i_jmp_br_addr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   entry_q [DEPTH];

    logic          req_c;
    logic          push_c;
    logic          pop_c;
    logic [CW:0]   credit_c;

    // Outstanding entries plus the one in flight must leave room for the response.
    assign credit_c = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign req_c    = (credit_c < (CW+1)'(DEPTH)) && !i_jmp_valid;
    assign push_c   = inflight_q && !i_jmp_valid;
    assign pop_c    = i_rd_en && (count_q != '0) && !i_jmp_valid;

    assign o_icache_addr       = pc_q;
    assign o_icache_rd_en      = req_c & i_rst_n;
    assign o_fetch_empty_flag  = (count_q == '0);
    assign o_fetch_pc_plus_4   = entry_q[rd_ptr_q][63:32];
    assign o_fetch_instruction = entry_q[rd_ptr_q][31:0];

    // Next-state: redirect flushes everything and kills the response arriving this cycle.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = req_c;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q + CW'(push_c) - CW'(pop_c);

        if (i_jmp_valid) begin
            pc_d     = i_jmp_br_addr;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (req_c) begin
                pc_d     = pc_q + 32'd4;
                req_pc_d = pc_q;
            end
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the count.
    always_ff @(posedge i_clk) begin
        if (push_c) begin
            entry_q[wr_ptr_q] <= {req_pc_q + 32'd4, i_icache_data};
        end
    end

endmodule
